mem_access_unit: RTL and testbench

//   Initiator for the data-side (memAccess) port of operational memory; issues load/store traffic to it.

---
 rtl/mem_access_unit.sv | 172 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
`timescale 1ns/1ps
// Data-side memory initiator: one load/store at a time on a word-addressed
// 32-bit port, with sub-word stores built as read-modify-write.
module mem_access_unit #(
    parameter int ADDR_WIDTH   = 16,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  reqValid,
    output logic                  reqReady,
    input  logic                  reqWrite,
    input  logic [1:0]            reqSize,
    input  logic                  reqSigned,
    input  logic [ADDR_WIDTH+1:0] reqAddress,
    input  logic [31:0]           reqData,
    output logic                  respValid,
    output logic                  respError,
    output logic [31:0]           respData,
    output logic [ADDR_WIDTH-1:0] memAccessAddress,
    output logic                  memAccessWren,
    output logic [31:0]           memAccessData,
    output logic                  memAccessRden,
    input  logic [31:0]           memAccessOutput
);

    localparam logic [1:0] SZ_B     = 2'b00;
    localparam logic [1:0] SZ_H     = 2'b01;
    localparam logic [1:0] SZ_W     = 2'b10;
    localparam logic [1:0] CNT_LAST = 2'(READ_LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_WRITE,
        S_RESP
    } state_t;

    state_t r_state;
    state_t w_next;

    logic                  r_write;
    logic [1:0]            r_size;
    logic                  r_signed;
    logic [1:0]            r_lane;
    logic [31:0]           r_wdata;
    logic [1:0]            r_cnt;
    logic [31:0]           r_respData;
    logic                  r_respError;
    logic [ADDR_WIDTH-1:0] r_memAddr;
    logic [31:0]           r_memData;

    logic w_accept;
    logic w_err;
    logic w_sample;
    logic w_wordStore;

    // Shift the addressed lane down to bit 0, then extend.
    function automatic logic [31:0] f_extract(
        input logic [31:0] word,
        input logic [1:0]  size,
        input logic [1:0]  lane,
        input logic        sgn
    );
        logic [31:0] sh;
        sh = word >> {lane, 3'b000};
        case (size)
            SZ_B:    f_extract = {{24{sgn & sh[7]}}, sh[7:0]};
            SZ_H:    f_extract = {{16{sgn & sh[15]}}, sh[15:0]};
            default: f_extract = word;
        endcase
    endfunction

    // Halfwords are 2-byte aligned here, so lane*8 is also the half offset.
    function automatic logic [31:0] f_merge(
        input logic [31:0] word,
        input logic [1:0]  size,
        input logic [1:0]  lane,
        input logic [31:0] data
    );
        logic [31:0] mask;
        logic [31:0] ins;
        mask = (size == SZ_B) ? 32'h0000_00FF : 32'h0000_FFFF;
        ins  = (data & mask) << {lane, 3'b000};
        mask = mask << {lane, 3'b000};
        f_merge = (word & ~mask) | ins;
    endfunction

    assign w_accept    = reqValid && (r_state == S_IDLE);
    assign w_err       = (reqSize == 2'b11)
                      || ((reqSize == SZ_H) && reqAddress[0])
                      || ((reqSize == SZ_W) && (reqAddress[1:0] != 2'b00));
    assign w_wordStore = reqWrite && (reqSize == SZ_W);
    assign w_sample    = (r_state == S_WAIT) && (r_cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_err)            w_next = S_RESP;
                    else if (w_wordStore) w_next = S_WRITE;
                    else                  w_next = S_READ;
                end
            end
            S_READ:  w_next = S_WAIT;
            S_WAIT:  if (w_sample) w_next = r_write ? S_WRITE : S_RESP;
            S_WRITE: w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_write     <= 1'b0;
            r_size      <= 2'b00;
            r_signed    <= 1'b0;
            r_lane      <= 2'b00;
            r_wdata     <= '0;
            r_cnt       <= '0;
            r_respData  <= '0;
            r_respError <= 1'b0;
            r_memAddr   <= '0;
            r_memData   <= '0;
        end else begin
            if (w_accept) begin
                r_write   <= reqWrite;
                r_size    <= reqSize;
                r_signed  <= reqSigned;
                r_lane    <= reqAddress[1:0];
                r_wdata   <= reqData;
                r_memAddr <= reqAddress[ADDR_WIDTH+1:2];
                if (w_err) begin
                    r_respError <= 1'b1;
                    r_respData  <= '0;
                end else if (w_wordStore) begin
                    r_memData <= reqData;
                end
            end
            r_cnt <= ((r_state == S_WAIT) && !w_sample) ? r_cnt + 2'd1 : 2'd0;
            if (w_sample) begin
                if (r_write) begin
                    r_memData <= f_merge(memAccessOutput, r_size, r_lane, r_wdata);
                end else begin
                    r_respData  <= f_extract(memAccessOutput, r_size, r_lane, r_signed);
                    r_respError <= 1'b0;
                end
            end
            if (r_state == S_WRITE) begin
                r_respData  <= '0;
                r_respError <= 1'b0;
            end
        end
    end

    assign reqReady         = (r_state == S_IDLE);
    assign respValid        = (r_state == S_RESP);
    assign respError        = r_respError;
    assign respData         = r_respData;
    assign memAccessRden    = (r_state == S_READ);
    assign memAccessWren    = (r_state == S_WRITE);
    assign memAccessAddress = r_memAddr;
    assign memAccessData    = r_memData;

endmodule

// File: tb/tb_mem_access_unit.sv
`timescale 1ns/1ps
// Bench for mem_access_unit: two instances (read latency 1 and 3) share one
// stimulus stream; a word-array reference model feeds per-instance scoreboards.
module tb_mem_access_unit;

    localparam int AW = 16;
    localparam int LA = 1;
    localparam int LB = 3;
    localparam int MW = 1024;

    typedef struct {
        int          acc;
        int          base;
        int          nrd;
        int          nwr;
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          reqValid;
    logic          reqWrite;
    logic [1:0]    reqSize;
    logic          reqSigned;
    logic [AW+1:0] reqAddress;
    logic [31:0]   reqData;

    logic          ready_a, rv_a, re_a, wren_a, rden_a;
    logic [31:0]   rd_a, wdata_a, out_a;
    logic [AW-1:0] addr_a;
    logic          ready_b, rv_b, re_b, wren_b, rden_b;
    logic [31:0]   rd_b, wdata_b, out_b;
    logic [AW-1:0] addr_b;

    int cyc = 0;
    int checks = 0;
    int failures = 0;
    int proto = 0;
    int rda = 0, wra = 0, rdb = 0, wrb = 0;
    int nra = 0, nrb = 0;

    logic [31:0] mem_a [MW];
    logic [31:0] mem_b [MW];
    logic [31:0] refmem [MW];
    logic [31:0] pipe_a [4];
    logic [31:0] pipe_b [4];
    exp_t qa[$];
    exp_t qb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_access_unit #(.ADDR_WIDTH(AW), .READ_LATENCY(LA)) dut_a (
        .clk(clk), .rst(rst),
        .reqValid(reqValid), .reqReady(ready_a),
        .reqWrite(reqWrite), .reqSize(reqSize), .reqSigned(reqSigned),
        .reqAddress(reqAddress), .reqData(reqData),
        .respValid(rv_a), .respError(re_a), .respData(rd_a),
        .memAccessAddress(addr_a), .memAccessWren(wren_a),
        .memAccessData(wdata_a), .memAccessRden(rden_a),
        .memAccessOutput(out_a)
    );

    mem_access_unit #(.ADDR_WIDTH(AW), .READ_LATENCY(LB)) dut_b (
        .clk(clk), .rst(rst),
        .reqValid(reqValid), .reqReady(ready_b),
        .reqWrite(reqWrite), .reqSize(reqSize), .reqSigned(reqSigned),
        .reqAddress(reqAddress), .reqData(reqData),
        .respValid(rv_b), .respError(re_b), .respData(rd_b),
        .memAccessAddress(addr_b), .memAccessWren(wren_b),
        .memAccessData(wdata_b), .memAccessRden(rden_b),
        .memAccessOutput(out_b)
    );

    function automatic logic [31:0] init_word(input int i);
        return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_1234;
    endfunction

    // Memories: read data appears L cycles after the rden cycle; garbage otherwise.
    always @(posedge clk) begin
        if (cyc == 0)
            for (int i = 0; i < MW; i++) mem_a[i] = init_word(i);
        if (wren_a) mem_a[addr_a[9:0]] = wdata_a;
        pipe_a[0] <= rden_a ? mem_a[addr_a[9:0]] : $urandom;
        for (int i = 1; i < 4; i++) pipe_a[i] <= pipe_a[i-1];
    end

    always @(posedge clk) begin
        if (cyc == 0)
            for (int i = 0; i < MW; i++) mem_b[i] = init_word(i);
        if (wren_b) mem_b[addr_b[9:0]] = wdata_b;
        pipe_b[0] <= rden_b ? mem_b[addr_b[9:0]] : $urandom;
        for (int i = 1; i < 4; i++) pipe_b[i] <= pipe_b[i-1];
    end

    assign out_a = pipe_a[LA-1];
    assign out_b = pipe_b[LB-1];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Reference model: byte-level view of a word array.
    task automatic model(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [AW+1:0] a, input logic [31:0] d, output exp_t e);
        int          wi;
        int          k;
        logic [31:0] word;
        logic [7:0]  b;
        logic [15:0] h;
        wi   = int'(a[11:2]);
        k    = int'(a[1:0]);
        word = refmem[wi];
        e.err  = (sz == 2'd3) || (sz == 2'd1 && k % 2 != 0) || (sz == 2'd2 && k != 0);
        e.data = 32'h0;
        e.nrd  = 0;
        e.nwr  = 0;
        e.acc  = 0;
        if (e.err) begin
            e.base = 1;
        end else if (w && sz == 2'd2) begin
            refmem[wi] = d;
            e.base = 2;
            e.nwr  = 1;
        end else if (w) begin
            if (sz == 2'd0) word[8*k +: 8] = d[7:0];
            else            word[8*k +: 16] = d[15:0];
            refmem[wi] = word;
            e.base = 3;
            e.nrd  = 1;
            e.nwr  = 1;
        end else begin
            e.base = 2;
            e.nrd  = 1;
            b = word[8*k +: 8];
            h = (k >= 2) ? word[31:16] : word[15:0];
            if (sz == 2'd0)      e.data = sg ? 32'($signed(b)) : 32'(b);
            else if (sz == 2'd1) e.data = sg ? 32'($signed(h)) : 32'(h);
            else                 e.data = word;
        end
    endtask

    always @(negedge clk) begin : mon_a
        exp_t e;
        if (rst) begin
            rda = 0;
            wra = 0;
        end else begin
            if (rden_a) rda++;
            if (wren_a) wra++;
            if (rden_a && wren_a) proto++;
            if (rv_a) begin
                nra++;
                if (qa.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL a_unexpected_resp got=1 expected=0 (t=%0t)", $time);
                end else begin
                    e = qa.pop_front();
                    chk("a_latency", cyc - e.acc, e.base + e.nrd * LA);
                    chk("a_respData", rd_a, e.data);
                    chk("a_respError", 32'(re_a), 32'(e.err));
                    chk("a_rden_cycles", rda, e.nrd);
                    chk("a_wren_cycles", wra, e.nwr);
                end
                rda = 0;
                wra = 0;
            end
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (rst) begin
            rdb = 0;
            wrb = 0;
        end else begin
            if (rden_b) rdb++;
            if (wren_b) wrb++;
            if (rden_b && wren_b) proto++;
            if (rv_b) begin
                nrb++;
                if (qb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL b_unexpected_resp got=1 expected=0 (t=%0t)", $time);
                end else begin
                    e = qb.pop_front();
                    chk("b_latency", cyc - e.acc, e.base + e.nrd * LB);
                    chk("b_respData", rd_b, e.data);
                    chk("b_respError", 32'(re_b), 32'(e.err));
                    chk("b_rden_cycles", rdb, e.nrd);
                    chk("b_wren_cycles", wrb, e.nwr);
                end
                rdb = 0;
                wrb = 0;
            end
        end
    end

    task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [AW+1:0] a, input logic [31:0] d);
        exp_t e;
        bit   done;
        model(w, sz, sg, a, d, e);
        @(posedge clk);
        #1;
        reqValid   = 1'b1;
        reqWrite   = w;
        reqSize    = sz;
        reqSigned  = sg;
        reqAddress = a;
        reqData    = d;
        @(negedge clk);
        e.acc = cyc;
        chk("req_ready", {30'b0, ready_a, ready_b}, 32'h3);
        qa.push_back(e);
        qb.push_back(e);
        @(posedge clk);
        #1;
        reqValid   = 1'b0;
        reqWrite   = 1'($urandom);
        reqSize    = 2'($urandom);
        reqSigned  = 1'($urandom);
        reqAddress = (AW+2)'($urandom);
        reqData    = $urandom;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            done = (qa.size() == 0) && (qb.size() == 0);
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL resp_timeout got=pending expected=response addr=%h", a);
            qa.delete();
            qb.delete();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int na0;
        int nb0;
        int mm_a;
        int mm_b;
        rst        = 1'b1;
        reqValid   = 1'b0;
        reqWrite   = 1'b0;
        reqSize    = 2'b00;
        reqSigned  = 1'b0;
        reqAddress = '0;
        reqData    = '0;
        for (int i = 0; i < MW; i++) refmem[i] = init_word(i);

        @(negedge clk);
        chk("rst_reqReady", 32'(ready_a), 32'h1);
        chk("rst_respValid", 32'(rv_a), 32'h0);
        chk("rst_respError", 32'(re_a), 32'h0);
        chk("rst_respData", rd_a, 32'h0);
        chk("rst_wren", 32'(wren_a), 32'h0);
        chk("rst_rden", 32'(rden_a), 32'h0);
        chk("rst_memAddr", 32'(addr_a), 32'h0);
        chk("rst_memData", wdata_a, 32'h0);
        chk("rst_b_ready", 32'(ready_b), 32'h1);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);

        issue(1'b1, 2'd2, 1'b0, 18'h00010, 32'hDEADBEEF);
        issue(1'b0, 2'd2, 1'b0, 18'h00010, 32'h0);
        issue(1'b1, 2'd0, 1'b0, 18'h00011, 32'h000000A5);
        issue(1'b0, 2'd0, 1'b1, 18'h00011, 32'h0);
        issue(1'b0, 2'd0, 1'b0, 18'h00011, 32'h0);
        issue(1'b0, 2'd1, 1'b1, 18'h00012, 32'h0);
        issue(1'b0, 2'd1, 1'b0, 18'h00010, 32'h0);
        issue(1'b0, 2'd2, 1'b0, 18'h00012, 32'h0);
        issue(1'b1, 2'd1, 1'b0, 18'h00011, 32'h00001234);
        issue(1'b0, 2'd3, 1'b0, 18'h00010, 32'h0);
        issue(1'b1, 2'd1, 1'b0, 18'h00016, 32'hCAFE7E57);
        issue(1'b0, 2'd2, 1'b0, 18'h00014, 32'h0);

        // Byte store aborted by reset while both units wait for read data.
        na0 = nra;
        nb0 = nrb;
        @(posedge clk);
        #1;
        reqValid   = 1'b1;
        reqWrite   = 1'b1;
        reqSize    = 2'd0;
        reqSigned  = 1'b0;
        reqAddress = 18'h00011;
        reqData    = 32'h0000003C;
        @(posedge clk);
        #1 reqValid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort_rden_a", 32'(rden_a), 32'h0);
        chk("abort_wren_a", 32'(wren_a), 32'h0);
        chk("abort_rden_b", 32'(rden_b), 32'h0);
        chk("abort_wren_b", 32'(wren_b), 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_ready_a", 32'(ready_a), 32'h1);
        chk("abort_ready_b", 32'(ready_b), 32'h1);
        repeat (6) @(negedge clk);
        chk("abort_no_resp_a", nra, na0);
        chk("abort_no_resp_b", nrb, nb0);
        issue(1'b0, 2'd2, 1'b0, 18'h00010, 32'h0);

        for (int n = 0; n < 150; n++) begin
            logic [1:0]    sz;
            logic [AW+1:0] a;
            sz = 2'($urandom_range(0, 3));
            a  = (AW+2)'($urandom_range(0, 127));
            if ($urandom_range(0, 1) == 1) begin
                if (sz == 2'd1)      a[0] = 1'b0;
                else if (sz == 2'd2) a[1:0] = 2'b00;
            end
            issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
        end

        repeat (4) @(negedge clk);
        mm_a = 0;
        mm_b = 0;
        for (int i = 0; i < MW; i++) begin
            if (mem_a[i] !== refmem[i]) mm_a++;
            if (mem_b[i] !== refmem[i]) mm_b++;
        end
        chk("mem_a_image_mismatches", mm_a, 0);
        chk("mem_b_image_mismatches", mm_b, 0);
        chk("rden_wren_overlap", proto, 0);
        chk("queue_a_left", qa.size(), 0);
        chk("queue_b_left", qb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
